// File: rtl/cond_reg_machine_pkg.sv
// Shared types for the conditional-register machine: FSM states and
// instruction opcode field encodings.
package cond_reg_machine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_CMP,
        ST_EXEC,
        ST_SCAN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ   = 2'd0,
        CMP_LT   = 2'd1,
        CMP_GT   = 2'd2,
        CMP_TRUE = 2'd3
    } cmp_op_t;

    localparam logic DST_ADD = 1'b0;
    localparam logic DST_SUB = 1'b1;

endpackage

// File: rtl/cond_reg_compare.sv
// Signed condition evaluator: eq/lt/gt/always, optionally inverted
// to give ne/ge/le/never.
module cond_reg_compare
    import cond_reg_machine_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    input  logic              neg,
    output logic              out
);

    logic raw;

    always_comb begin
        raw = 1'b0;
        case (cmp_op_t'(op))
            CMP_EQ:   raw = (a == b);
            CMP_LT:   raw = ($signed(a) <  $signed(b));
            CMP_GT:   raw = ($signed(a) >  $signed(b));
            CMP_TRUE: raw = 1'b1;
            default:  raw = 1'b0;
        endcase
        out = raw ^ neg;
    end

endmodule

// File: rtl/cond_reg_machine.sv
// Conditional-register machine: fetches 3-word instructions from an
// async-read memory, runs them until HALT, then scans for the final maximum.
module cond_reg_machine
    import cond_reg_machine_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WORD_W = 16,
    parameter int IDX_W  = 6,
    parameter int NREGS  = 64,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] final_max,
    output logic [CNT_W-1:0]  instr_count,
    output logic              err
);

    state_t state, state_nxt;

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] opc_q;
    logic [DATA_W-1:0] cmp_imm_q;
    logic [DATA_W-1:0] cmp_val_q;
    logic [IDX_W-1:0]  scan_idx;

    logic              opc_neg;
    logic [1:0]        opc_cmp;
    logic              opc_dst;
    logic [IDX_W-1:0]  cmp_idx;
    logic [IDX_W-1:0]  dst_idx;
    logic              cmp_ok;
    logic              dst_ok;
    logic              is_halt;
    logic              scan_last;
    logic              cond_pass;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] cmp_rd;
    logic [DATA_W-1:0] dst_rd;
    logic [DATA_W-1:0] scan_rd;
    logic [DATA_W-1:0] wr_val;

    assign opc_neg   = opc_q[WORD_W-1];
    assign opc_cmp   = opc_q[WORD_W-2 -: 2];
    assign opc_dst   = opc_q[WORD_W-4];
    assign cmp_idx   = opc_q[2*IDX_W-1 -: IDX_W];
    assign dst_idx   = opc_q[IDX_W-1:0];
    assign cmp_ok    = int'(cmp_idx) < NREGS;
    assign dst_ok    = int'(dst_idx) < NREGS;
    assign is_halt   = (mem_data == '1);
    assign scan_last = (scan_idx == IDX_W'(NREGS - 1));
    // Truncates as well as sign-extends, so narrow DATA_W builds stay legal
    assign imm_ext   = DATA_W'(signed'(mem_data));
    assign mem_addr  = pc;

    // Three read ports: compare operand, destination operand, final scan
    assign cmp_rd  = cmp_ok ? regs[cmp_idx] : '0;
    assign dst_rd  = dst_ok ? regs[dst_idx] : '0;
    assign scan_rd = regs[scan_idx];
    assign wr_val  = (opc_dst == DST_SUB) ? dst_rd - imm_ext : dst_rd + imm_ext;

    cond_reg_compare #(
        .DATA_W (DATA_W)
    ) u_compare (
        .a   (cmp_val_q),
        .b   (cmp_imm_q),
        .op  (opc_cmp),
        .neg (opc_neg),
        .out (cond_pass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_FETCH_OP;
            ST_FETCH_OP:  state_nxt = is_halt ? ST_SCAN : ST_FETCH_CMP;
            ST_FETCH_CMP: state_nxt = ST_EXEC;
            ST_EXEC:      state_nxt = ST_FETCH_OP;
            ST_SCAN:      if (scan_last) state_nxt = ST_DONE;
            ST_DONE:      if (start) state_nxt = ST_FETCH_OP;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_FETCH_OP, ST_FETCH_CMP, ST_EXEC, ST_SCAN: busy = 1'b1;
            ST_DONE:                                     done = 1'b1;
            default:                                     ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            pc          <= '0;
            opc_q       <= '0;
            cmp_imm_q   <= '0;
            cmp_val_q   <= '0;
            scan_idx    <= '0;
            peak_max    <= '0;
            final_max   <= '0;
            instr_count <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
                        pc          <= '0;
                        peak_max    <= '0;
                        final_max   <= '0;
                        instr_count <= '0;
                        err         <= 1'b0;
                    end
                end
                ST_FETCH_OP: begin
                    if (is_halt) begin
                        scan_idx <= '0;
                    end else begin
                        opc_q <= mem_data;
                        pc    <= pc + 1'b1;
                    end
                end
                ST_FETCH_CMP: begin
                    cmp_imm_q <= imm_ext;
                    cmp_val_q <= cmp_rd;
                    pc        <= pc + 1'b1;
                end
                ST_EXEC: begin
                    if (cond_pass && dst_ok) begin
                        regs[dst_idx] <= wr_val;
                        if ($signed(wr_val) > $signed(peak_max)) peak_max <= wr_val;
                    end
                    if (!cmp_ok || !dst_ok) err <= 1'b1;
                    if (instr_count != '1) instr_count <= instr_count + 1'b1;
                    pc <= pc + 1'b1;
                end
                ST_SCAN: begin
                    if (scan_idx == '0 || $signed(scan_rd) > $signed(final_max))
                        final_max <= scan_rd;
                    scan_idx <= scan_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_reg_machine.sv
// Directed bench for cond_reg_machine: hand-assembled programs with
// hand-computed results, including an 8-bit-wide instance for wrap checks.
module tb_cond_reg_machine;
    import cond_reg_machine_pkg::*;

    logic        clk;
    logic        reset;
    logic        start, start8;
    logic        busy, done, busy8, done8;
    logic [15:0] mem_addr, mem_addr8;
    logic [15:0] mem_data, mem_data8;
    logic [31:0] peak_max, final_max;
    logic [7:0]  peak_max8, final_max8;
    logic [15:0] instr_count, instr_count8;
    logic        err, err8;

    logic [15:0] mem  [256];
    logic [15:0] mem8 [256];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    always_comb mem_data  = mem[mem_addr[7:0]];
    always_comb mem_data8 = mem8[mem_addr8[7:0]];

    cond_reg_machine #(
        .DATA_W (32), .WORD_W (16), .IDX_W (6), .NREGS (26), .ADDR_W (16), .CNT_W (16)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .busy (busy), .done (done),
        .mem_addr (mem_addr), .mem_data (mem_data), .peak_max (peak_max),
        .final_max (final_max), .instr_count (instr_count), .err (err)
    );

    cond_reg_machine #(
        .DATA_W (8), .WORD_W (16), .IDX_W (6), .NREGS (26), .ADDR_W (16), .CNT_W (16)
    ) dut8 (
        .clk (clk), .reset (reset), .start (start8), .busy (busy8), .done (done8),
        .mem_addr (mem_addr8), .mem_data (mem_data8), .peak_max (peak_max8),
        .final_max (final_max8), .instr_count (instr_count8), .err (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] opc(input logic neg, input logic [1:0] cop,
                                        input logic dop, input logic [5:0] ci,
                                        input logic [5:0] di);
        return {neg, cop, dop, ci, di};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'hFFFF;
            mem8[i] = 16'hFFFF;
        end
    endtask

    task automatic put(input int a, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2);
        mem[a] = w0; mem[a+1] = w1; mem[a+2] = w2;
    endtask

    // a=0 b=1 c=2
    task automatic load_prog1();
        clear_mem();
        put(0, opc(1'b0, CMP_GT, DST_ADD, 6'd0, 6'd1), 16'd1,  16'd5);
        put(3, opc(1'b0, CMP_LT, DST_ADD, 6'd1, 6'd0), 16'd5,  16'd1);
        put(6, opc(1'b1, CMP_LT, DST_SUB, 6'd0, 6'd2), 16'd1,  16'hFFF6);
        put(9, opc(1'b0, CMP_EQ, DST_ADD, 6'd2, 6'd2), 16'd10, 16'hFFEC);
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!done && c < 500) begin
            tick();
            c++;
        end
    endtask

    task automatic run(output int c);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c);
    endtask

    task automatic chk_prog1(input string p, input int c);
        chk({p, "_latency"}, 64'(c), 64'd40);
        chk({p, "_done"},    {63'b0, done}, 64'd1);
        chk({p, "_busy"},    {63'b0, busy}, 64'd0);
        chk({p, "_final"},   {32'b0, final_max}, 64'd1);
        chk({p, "_peak"},    {32'b0, peak_max}, 64'd10);
        chk({p, "_count"},   {48'b0, instr_count}, 64'd4);
        chk({p, "_err"},     {63'b0, err}, 64'd0);
        chk({p, "_reg_c"},   {32'b0, dut.regs[2]}, 64'hFFFF_FFF6);
    endtask

    initial begin
        logic anyset;
        reset  = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
        clear_mem();
        repeat (2) tick();

        chk("rst_busy",  {63'b0, busy}, 64'd0);
        chk("rst_done",  {63'b0, done}, 64'd0);
        chk("rst_addr",  {48'b0, mem_addr}, 64'd0);
        chk("rst_peak",  {32'b0, peak_max}, 64'd0);
        chk("rst_final", {32'b0, final_max}, 64'd0);
        chk("rst_count", {48'b0, instr_count}, 64'd0);
        chk("rst_err",   {63'b0, err}, 64'd0);
        reset = 1'b0;
        tick();

        load_prog1();
        run(cyc);
        chk_prog1("s1", cyc);
        chk("s1_reg_a", {32'b0, dut.regs[0]}, 64'd1);

        clear_mem();
        put(0, opc(1'b0, CMP_TRUE, DST_ADD, 6'd1, 6'd0), 16'd0, 16'd7);
        put(3, opc(1'b1, CMP_TRUE, DST_ADD, 6'd0, 6'd1), 16'd0, 16'd7);
        run(cyc);
        chk("s2_latency", 64'(cyc), 64'd34);
        chk("s2_reg_a",   {32'b0, dut.regs[0]}, 64'd7);
        chk("s2_reg_b",   {32'b0, dut.regs[1]}, 64'd0);
        chk("s2_peak",    {32'b0, peak_max}, 64'd7);
        chk("s2_final",   {32'b0, final_max}, 64'd7);
        chk("s2_count",   {48'b0, instr_count}, 64'd2);

        clear_mem();
        mem8[0] = opc(1'b0, CMP_TRUE, DST_ADD, 6'd0, 6'd0); mem8[1] = 16'd0; mem8[2] = 16'd127;
        mem8[3] = opc(1'b0, CMP_TRUE, DST_ADD, 6'd0, 6'd0); mem8[4] = 16'd0; mem8[5] = 16'd1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("s3_done",  {63'b0, done8}, 64'd1);
        chk("s3_reg_a", {56'b0, dut8.regs[0]}, 64'h80);
        chk("s3_peak",  {56'b0, peak_max8}, 64'h7F);
        chk("s3_final", {56'b0, final_max8}, 64'd0);
        chk("s3_count", {48'b0, instr_count8}, 64'd2);

        clear_mem();
        put(0, opc(1'b0, CMP_TRUE, DST_ADD, 6'd0, 6'd40), 16'd0, 16'd3);
        run(cyc);
        anyset = 1'b0;
        for (int i = 0; i < 26; i++) anyset = anyset | (|dut.regs[i]);
        chk("s4_err",   {63'b0, err}, 64'd1);
        chk("s4_count", {48'b0, instr_count}, 64'd1);
        chk("s4_peak",  {32'b0, peak_max}, 64'd0);
        chk("s4_regs",  {63'b0, anyset}, 64'd0);

        load_prog1();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("s5_in_exec", {61'b0, dut.state}, {61'b0, ST_EXEC});
        chk("s5_pre_count", {48'b0, instr_count}, 64'd1);
        reset = 1'b1;
        #1;
        chk("s5_rst_busy",  {63'b0, busy}, 64'd0);
        chk("s5_rst_addr",  {48'b0, mem_addr}, 64'd0);
        chk("s5_rst_count", {48'b0, instr_count}, 64'd0);
        chk("s5_rst_state", {61'b0, dut.state}, {61'b0, ST_IDLE});
        tick();
        reset = 1'b0;
        tick();
        run(cyc);
        chk_prog1("s5", cyc);

        start = 1'b1;
        tick();
        wait_done(cyc);
        chk_prog1("s6a", cyc);
        tick();
        chk("s6_restart_busy",  {63'b0, busy}, 64'd1);
        chk("s6_restart_count", {48'b0, instr_count}, 64'd0);
        start = 1'b0;
        wait_done(cyc);
        chk_prog1("s6b", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
